obf_key_loader: RTL and testbench
=================================

Name: obf_key_loader

Overview:
- Serial key-delivery stage that sits directly upstream of the MUX2-locked c432 netlist.
- Shifts in an obfuscation key plus a parity bit from a test or tamper-safe port, checks it, and commits it to a key register.
- Drives the locked netlist's key inputs (s_0, s_1, ... concatenated as key_out).
- key_out is forced to all-zero (a wrong key) except in LOCKED, so the netlist never sees a partially loaded or unverified key.

Parameters:
KEY_W, 2, number of key bits; key_out[0] drives s_0, key_out[1] drives s_1, and so on; legal range 1..64
PARITY_ODD, 0, 0 = even parity over key+parity bit, 1 = odd
MAX_TRIES, 3, failed parity checks tolerated before permanent DEAD; legal range 1..15
RELOAD_EN, 1, 1 = load_start accepted while LOCKED; 0 = ignored

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  single-cycle request to begin or restart a key load
key_sin  input  1  serial key data, MSB first, followed by one parity bit
key_sin_valid  input  1  key_sin is sampled only in cycles where this is high
key_out  output  KEY_W  committed key to the locked netlist; zero unless LOCKED
key_ready  output  1  high only in LOCKED
busy  output  1  high in SHIFT or PARITY
err  output  1  high in ERROR or DEAD
dead  output  1  high in DEAD

Behaviour:
Reset:
- Synchronous, active-high; clk and rst are the only clock and reset.
- On reset: state=IDLE, shadow=0, key_reg=0, bit_cnt=0, fail_cnt=0.
- All outputs are 0 on reset.
- Reset mid-load discards the shadow contents; fail_cnt returns to 0.

States: IDLE, SHIFT, PARITY, LOCKED, ERROR, DEAD.

IDLE:
- load_start -> SHIFT; bit_cnt=0, shadow=0.

SHIFT:
- Each cycle with key_sin_valid high: shadow <= {shadow[KEY_W-2:0], key_sin}; bit_cnt++.
- When the KEY_W-th bit is accepted -> PARITY.
- Cycles with key_sin_valid low hold all state; there is no timeout.

PARITY:
- The next valid beat is the parity bit p.
- Check passes when (^shadow ^ p) == PARITY_ODD.
- Pass: key_reg<=shadow, fail_cnt<=0 -> LOCKED.
- Fail: fail_cnt++ -> ERROR, or -> DEAD if the incremented fail_cnt equals MAX_TRIES.

LOCKED:
- key_out=key_reg, key_ready=1.
- With RELOAD_EN=1, load_start -> SHIFT: key_reg is cleared and key_out=0 from the next cycle onward.
- With RELOAD_EN=0, load_start is ignored.

ERROR:
- err=1, key_out=0, shadow held (never exposed on any output).
- load_start -> SHIFT (retry).

DEAD:
- err=1, dead=1, key_out=0.
- Ignores every input except rst.

Timing and boundary rules:
- load_start in SHIFT or PARITY restarts the load: bit_cnt=0, shadow=0, state=SHIFT. fail_cnt is unchanged.
- If load_start and key_sin_valid are both high in the same cycle, load_start wins and that data bit is discarded.
- A full load takes exactly KEY_W+1 valid beats.
- key_ready and key_out update in the cycle after the parity beat is sampled, i.e. one cycle of latency; output is registered.
- KEY_W=1: shadow is a single flop; the shift degenerates to shadow<=key_sin.
- fail_cnt width is $clog2(MAX_TRIES+1); it saturates and never wraps.
- All outputs come straight from flops or from state decode; there are no combinational paths from inputs to key_out.

Decomposition:
- Package obf_key_pkg holds:
  - the state enum key_state_t (3 bits, encodings 0..5);
  - the function parity_ok(shadow, p, odd);
  - localparams for the default KEY_W and MAX_TRIES.
- One sub-module, obf_key_shreg: KEY_W-bit shift register with clear, shift-enable and bit counter. Outputs shadow, done and the running XOR.
- The top level holds the FSM, fail counter, key_reg and output gating.

Test Plan (KEY_W=2, PARITY_ODD=0, MAX_TRIES=3 unless stated):
1. rst; load_start; valid beats 1,0,p=1 -> key_out=2'b10 and key_ready=1 exactly 1 cycle after the p beat; busy=1 for the 3 beats before that.
2. Same stream with valid low for 5 cycles between each beat -> identical result; key_out stays 0 throughout loading.
3. Beats 1,1,p=1 -> ERROR, err=1, key_out=0; retry with 1,1,p=0 -> LOCKED, key_out=2'b11, fail_cnt=0.
4. Three consecutive bad-parity loads -> dead=1 after the third; a subsequent valid load is ignored and key_out remains 0 until rst.
5. LOCKED with key 2'b01, RELOAD_EN=1: load_start -> key_out=0 next cycle; reload 1,0,p=1 -> key_out=2'b10. With RELOAD_EN=0, the same load_start leaves key_out=2'b01.
6. Mid-SHIFT after one beat: assert load_start together with key_sin_valid -> bit discarded, bit_cnt=0. Assert rst mid-SHIFT -> all outputs 0 in the next cycle.

Source files
------------

// File: rtl/obf_key_pkg.sv
// Shared types and helpers for the obfuscation key loader.
// Holds the FSM state encoding and the parity check function.
package obf_key_pkg;

    localparam int DEF_KEY_W     = 2;
    localparam int DEF_MAX_TRIES = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4,
        ST_DEAD   = 3'd5
    } key_state_t;

    function automatic logic parity_ok(
        input logic [63:0] shadow,
        input logic        p,
        input logic        odd
    );
        return ((^shadow) ^ p) == odd;
    endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow shift register for the serial key, with bit counter.
// Also keeps a running XOR of every accepted bit.
module obf_key_shreg
    import obf_key_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             done,
    output logic             par
);

    localparam int CW = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        if (clr) begin
            shadow_d = '0;
            cnt_d    = '0;
            par_d    = 1'b0;
        end else if (shift_en) begin
            // Left shift works for KEY_W=1 too: the old bit falls off.
            shadow_d = (shadow_q << 1) | KEY_W'(bit_in);
            cnt_d    = cnt_q + 1'b1;
            par_d    = par_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
        end
    end

    assign shadow = shadow_q;
    assign done   = (cnt_q == CW'(KEY_W - 1));
    assign par    = par_q;

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader feeding the key inputs of the locked c432 netlist.
// key_out stays zero unless a parity-checked key is committed.
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int KEY_W      = DEF_KEY_W,
    parameter int PARITY_ODD = 0,
    parameter int MAX_TRIES  = DEF_MAX_TRIES,
    parameter int RELOAD_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_sin,
    input  logic             key_sin_valid,
    output logic [KEY_W-1:0] key_out,
    output logic             key_ready,
    output logic             busy,
    output logic             err,
    output logic             dead
);

    localparam int FW = $clog2(MAX_TRIES + 1);

    key_state_t       state_q, state_d;
    logic [FW-1:0]    fail_q, fail_d, fail_inc;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] shadow_w;
    logic             done_w, par_w, pass_w;
    logic             clr, shift_en;

    obf_key_shreg #(.KEY_W(KEY_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .bit_in   (key_sin),
        .shadow   (shadow_w),
        .done     (done_w),
        .par      (par_w)
    );

    assign pass_w   = parity_ok(64'(par_w), key_sin, 1'(PARITY_ODD));
    assign fail_inc = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        key_d    = key_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (load_start) begin
                    clr     = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (load_start) begin
                    clr = 1'b1;
                end else if (key_sin_valid) begin
                    shift_en = 1'b1;
                    if (done_w) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (load_start) begin
                    clr     = 1'b1;
                    state_d = ST_SHIFT;
                end else if (key_sin_valid) begin
                    if (pass_w) begin
                        key_d   = shadow_w;
                        fail_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        fail_d  = fail_inc;
                        state_d = (fail_inc == FW'(MAX_TRIES)) ? ST_DEAD : ST_ERROR;
                    end
                end
            end
            ST_LOCKED: begin
                if (load_start && (RELOAD_EN != 0)) begin
                    clr     = 1'b1;
                    key_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_DEAD: begin
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fail_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            key_q   <= key_d;
        end
    end

    assign key_ready = (state_q == ST_LOCKED);
    assign key_out   = key_ready ? key_q : '0;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign err       = (state_q == ST_ERROR) || (state_q == ST_DEAD);
    assign dead      = (state_q == ST_DEAD);

endmodule

// File: tb/tb_obf_key_loader.sv
// Directed bench for obf_key_loader (KEY_W=2, even parity, MAX_TRIES=3).
// A second instance with RELOAD_EN=0 shares the same stimulus.
module tb_obf_key_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_start = 1'b0;
    logic       key_sin = 1'b0;
    logic       key_sin_valid = 1'b0;
    logic [1:0] key_out, nr_key_out;
    logic       key_ready, busy, err, dead;
    logic       nr_key_ready, nr_busy, nr_err, nr_dead;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    obf_key_loader #(.KEY_W(2), .PARITY_ODD(0), .MAX_TRIES(3), .RELOAD_EN(1)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .key_sin(key_sin),
        .key_sin_valid(key_sin_valid), .key_out(key_out), .key_ready(key_ready),
        .busy(busy), .err(err), .dead(dead)
    );

    obf_key_loader #(.KEY_W(2), .PARITY_ODD(0), .MAX_TRIES(3), .RELOAD_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .load_start(load_start), .key_sin(key_sin),
        .key_sin_valid(key_sin_valid), .key_out(nr_key_out), .key_ready(nr_key_ready),
        .busy(nr_busy), .err(nr_err), .dead(nr_dead)
    );

    always #5 clk = ~clk;

    // Present inputs for one rising edge, then sample 1 time unit after it.
    task automatic step(input logic ls, input logic v, input logic d);
        load_start = ls;
        key_sin_valid = v;
        key_sin = d;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        key_sin_valid = 1'b0;
        key_sin = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic load(input logic b1, input logic b0, input logic p);
        step(1, 0, 0);
        step(0, 1, b1);
        step(0, 1, b0);
        step(0, 1, p);
    endtask

    task automatic test_reset();
        do_reset();
        tot_cnt++; if ({key_out, key_ready, busy, err, dead} !== 6'b0)
            $display("FAIL reset_outs got=%b exp=000000", {key_out, key_ready, busy, err, dead});
        else pass_cnt++;
        tot_cnt++; if ({nr_key_out, nr_key_ready, nr_busy, nr_err, nr_dead} !== 6'b0)
            $display("FAIL reset_outs_nr got=%b exp=000000",
                     {nr_key_out, nr_key_ready, nr_busy, nr_err, nr_dead});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 0, 0);
        tot_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy0 got=%b exp=1", busy);
        else pass_cnt++;
        step(0, 1, 1);
        tot_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy1 got=%b exp=1", busy);
        else pass_cnt++;
        step(0, 1, 0);
        tot_cnt++; if ({busy, key_ready, key_out} !== 4'b1000)
            $display("FAIL basic_busy2 got=%b exp=1000", {busy, key_ready, key_out});
        else pass_cnt++;
        step(0, 1, 1);
        tot_cnt++; if ({key_ready, key_out} !== 3'b110)
            $display("FAIL basic_lock got=%b exp=110", {key_ready, key_out});
        else pass_cnt++;
        tot_cnt++; if ({busy, err} !== 2'b00)
            $display("FAIL basic_flags got=%b exp=00", {busy, err});
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        logic [2:0] beats;
        beats = 3'b101;
        do_reset();
        step(1, 0, 0);
        for (int b = 2; b >= 0; b--) begin
            for (int g = 0; g < 5; g++) begin
                step(0, 0, 0);
                tot_cnt++; if ({busy, key_ready, key_out} !== 4'b1000)
                    $display("FAIL gap_hold b=%0d g=%0d got=%b exp=1000", b, g,
                             {busy, key_ready, key_out});
                else pass_cnt++;
            end
            step(0, 1, beats[b]);
        end
        tot_cnt++; if ({key_ready, key_out} !== 3'b110)
            $display("FAIL gap_lock got=%b exp=110", {key_ready, key_out});
        else pass_cnt++;
    endtask

    task automatic test_error_retry();
        do_reset();
        load(1, 1, 1);
        tot_cnt++; if ({err, dead, key_ready, key_out} !== 5'b10000)
            $display("FAIL err_first got=%b exp=10000", {err, dead, key_ready, key_out});
        else pass_cnt++;
        load(1, 1, 0);
        tot_cnt++; if ({err, key_ready, key_out} !== 4'b0111)
            $display("FAIL err_retry got=%b exp=0111", {err, key_ready, key_out});
        else pass_cnt++;
        // Fail counter must have cleared: two more failures stay short of DEAD.
        load(1, 1, 1);
        load(0, 0, 1);
        tot_cnt++; if ({err, dead} !== 2'b10)
            $display("FAIL err_cnt_clr got=%b exp=10", {err, dead});
        else pass_cnt++;
    endtask

    task automatic test_dead();
        do_reset();
        load(1, 0, 0);
        load(0, 1, 0);
        tot_cnt++; if ({err, dead} !== 2'b10)
            $display("FAIL dead_two got=%b exp=10", {err, dead});
        else pass_cnt++;
        load(0, 0, 1);
        tot_cnt++; if ({err, dead, key_out} !== 4'b1100)
            $display("FAIL dead_third got=%b exp=1100", {err, dead, key_out});
        else pass_cnt++;
        load(1, 0, 1);
        tot_cnt++; if ({dead, busy, key_ready, key_out} !== 5'b10000)
            $display("FAIL dead_ignore got=%b exp=10000", {dead, busy, key_ready, key_out});
        else pass_cnt++;
        do_reset();
        tot_cnt++; if ({err, dead} !== 2'b00)
            $display("FAIL dead_rst got=%b exp=00", {err, dead});
        else pass_cnt++;
    endtask

    task automatic test_reload();
        do_reset();
        load(0, 1, 1);
        tot_cnt++; if ({key_out, nr_key_out} !== 4'b0101)
            $display("FAIL rl_lock got=%b exp=0101", {key_out, nr_key_out});
        else pass_cnt++;
        step(1, 0, 0);
        tot_cnt++; if ({key_ready, busy, key_out} !== 4'b0100)
            $display("FAIL rl_clear got=%b exp=0100", {key_ready, busy, key_out});
        else pass_cnt++;
        tot_cnt++; if ({nr_key_ready, nr_key_out} !== 3'b101)
            $display("FAIL rl_noreload got=%b exp=101", {nr_key_ready, nr_key_out});
        else pass_cnt++;
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 1);
        tot_cnt++; if ({key_ready, key_out} !== 3'b110)
            $display("FAIL rl_new got=%b exp=110", {key_ready, key_out});
        else pass_cnt++;
        tot_cnt++; if (nr_key_out !== 2'b01)
            $display("FAIL rl_nr_keep got=%b exp=01", nr_key_out);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        do_reset();
        step(1, 0, 0);
        step(0, 1, 1);
        step(1, 1, 1);
        step(0, 1, 0);
        step(0, 1, 1);
        tot_cnt++; if ({busy, key_ready} !== 2'b10)
            $display("FAIL rs_cnt got=%b exp=10", {busy, key_ready});
        else pass_cnt++;
        step(0, 1, 1);
        tot_cnt++; if ({key_ready, key_out} !== 3'b101)
            $display("FAIL rs_key got=%b exp=101", {key_ready, key_out});
        else pass_cnt++;
        step(1, 0, 0);
        step(0, 1, 1);
        rst = 1'b1;
        step(0, 1, 0);
        rst = 1'b0;
        tot_cnt++; if ({key_out, key_ready, busy, err, dead} !== 6'b0)
            $display("FAIL rs_rst got=%b exp=000000", {key_out, key_ready, busy, err, dead});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_error_retry();
        test_dead();
        test_reload();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
